// File: rtl/core_pkg.sv
// Shared fetch-front-end types and constants: FSM state encoding, NOP word,
// bundle size and the in-flight tracker entry layout.
package core_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FLUSH = 2'd3
  } fetch_state_e;

  localparam int unsigned FETCH_BYTES = 8;
  localparam logic [31:0] NOP_INSN    = {3'b111, 29'b0};

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [1:0]  mask;
  } track_entry_t;

endpackage

// File: rtl/fetch_track.sv
// In-flight bundle tracker: DEPTH-deep shift register of {valid, pc, mask}
// matching the ROM read latency. Synchronous clear drops only the valid bits.
module fetch_track
  import core_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr_i,
  input  logic         shift_i,
  input  track_entry_t push_i,
  output track_entry_t tail_o
);

  track_entry_t q_q [DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) q_q[i] <= '0;
    end else if (clr_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) q_q[i].valid <= 1'b0;
    end else if (shift_i) begin
      q_q[0] <= push_i;
      for (int unsigned i = 1; i < DEPTH; i++) q_q[i] <= q_q[i-1];
    end
  end

  assign tail_o = q_q[DEPTH-1];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives the ROM address, follows redirects and
// reports which ROM read-data bundles are live once the read latency elapses.
//
// state | meaning
// BOOT  | first ROM_LATENCY advances after reset, pipe filling
// RUN   | steady streaming
// HOLD  | stall/interlock, everything frozen; resumes prior state
// FLUSH | refilling after a redirect, ROM_LATENCY advances to go
module fetch_ctrl #(
  parameter int unsigned ROM_LATENCY = 1,
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int unsigned FETCH_BYTES = core_pkg::FETCH_BYTES
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        interlock,
  input  logic        fetch_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic        deliver_valid,
  output logic [31:0] deliver_pc,
  output logic [1:0]  deliver_mask,
  output logic        bubble
);
  import core_pkg::*;

  localparam logic [2:0]  LAT  = 3'(ROM_LATENCY);
  localparam logic [31:0] STEP = 32'(FETCH_BYTES);

  fetch_state_e state_q, prior_q, resume;
  logic [2:0]   cnt_q;
  logic [31:0]  pc_q;
  logic [1:0]   first_mask_q;
  logic         advance;
  track_entry_t push, tail;

  assign advance = ~fetch_stall & ~interlock;
  assign resume  = (state_q == ST_HOLD) ? prior_q : state_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q         <= RESET_PC;
      state_q      <= ST_BOOT;
      prior_q      <= ST_BOOT;
      cnt_q        <= LAT;
      first_mask_q <= 2'b11;
    end else if (redirect_valid) begin
      pc_q         <= {redirect_pc[31:3], 3'b000};
      state_q      <= ST_FLUSH;
      prior_q      <= ST_FLUSH;
      cnt_q        <= LAT;
      // A target in the upper word kills slot0 of the first bundle.
      first_mask_q <= {1'b1, ~redirect_pc[2]};
    end else if (advance) begin
      pc_q         <= pc_q + STEP;
      first_mask_q <= 2'b11;
      if (resume == ST_RUN) begin
        state_q <= ST_RUN;
      end else if (cnt_q <= 3'd1) begin
        state_q <= ST_RUN;
        cnt_q   <= 3'd0;
      end else begin
        state_q <= resume;
        cnt_q   <= cnt_q - 3'd1;
      end
    end else if (state_q != ST_HOLD) begin
      prior_q <= state_q;
      state_q <= ST_HOLD;
    end
  end

  assign push = '{valid: 1'b1, pc: pc_q, mask: first_mask_q};

  fetch_track #(.DEPTH(ROM_LATENCY)) u_track (
    .clk     (clk),
    .rstn    (rstn),
    .clr_i   (redirect_valid),
    .shift_i (advance),
    .push_i  (push),
    .tail_o  (tail)
  );

  assign pc            = pc_q;
  assign deliver_valid = tail.valid;
  assign deliver_pc    = tail.pc;
  assign deliver_mask  = tail.mask;
  // Held low during reset so the perf tap never counts reset cycles.
  assign bubble        = rstn & advance & ~tail.valid;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed, table-driven bench for fetch_ctrl: one instance at ROM latency 1
// and one at latency 3 (non-zero reset PC), plus reset checks.
module tb_fetch_ctrl;

  typedef struct {
    logic        st;
    logic        il;
    logic        rv;
    logic [31:0] rp;
    logic [31:0] pc;
    logic        dv;
    logic [31:0] dpc;
    logic [1:0]  m;
    logic        bub;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        st1 = 0, il1 = 0, rv1 = 0, st3 = 0, il3 = 0, rv3 = 0;
  logic [31:0] rp1 = 0, rp3 = 0;
  logic [31:0] pc1, dpc1, pc3, dpc3;
  logic        dv1, bub1, dv3, bub3;
  logic [1:0]  m1, m3;

  int tests = 0;
  int fails = 0;

  vec_t t1[$];
  vec_t t3[$];

  always #5 clk = ~clk;

  fetch_ctrl #(.ROM_LATENCY(1)) u1 (
    .clk(clk), .rstn(rstn), .interlock(il1), .fetch_stall(st1),
    .redirect_valid(rv1), .redirect_pc(rp1), .pc(pc1),
    .deliver_valid(dv1), .deliver_pc(dpc1), .deliver_mask(m1), .bubble(bub1)
  );

  fetch_ctrl #(.ROM_LATENCY(3), .RESET_PC(32'h1000)) u3 (
    .clk(clk), .rstn(rstn), .interlock(il3), .fetch_stall(st3),
    .redirect_valid(rv3), .redirect_pc(rp3), .pc(pc3),
    .deliver_valid(dv3), .deliver_pc(dpc3), .deliver_mask(m3), .bubble(bub3)
  );

  function automatic vec_t mk(logic st, logic il, logic rv, logic [31:0] rp,
                              logic [31:0] pc, logic dv, logic [31:0] dpc,
                              logic [1:0] m, logic bub);
    vec_t v;
    v.st = st; v.il = il; v.rv = rv; v.rp = rp;
    v.pc = pc; v.dv = dv; v.dpc = dpc; v.m = m; v.bub = bub;
    return v;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d] got %h want %h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle's inputs, check that cycle's outputs, move to next negedge.
  task automatic apply(input vec_t v, input bit sel3, input int idx);
    if (sel3) begin
      st3 = v.st; il3 = v.il; rv3 = v.rv; rp3 = v.rp;
      st1 = 0;    il1 = 0;    rv1 = 0;    rp1 = 0;
    end else begin
      st1 = v.st; il1 = v.il; rv1 = v.rv; rp1 = v.rp;
      st3 = 0;    il3 = 0;    rv3 = 0;    rp3 = 0;
    end
    #1;
    if (sel3) begin
      chk("l3_pc", idx, pc3, v.pc);
      chk("l3_valid", idx, 32'(dv3), 32'(v.dv));
      chk("l3_bubble", idx, 32'(bub3), 32'(v.bub));
      if (v.dv) begin
        chk("l3_dpc", idx, dpc3, v.dpc);
        chk("l3_mask", idx, 32'(m3), 32'(v.m));
      end
    end else begin
      chk("l1_pc", idx, pc1, v.pc);
      chk("l1_valid", idx, 32'(dv1), 32'(v.dv));
      chk("l1_bubble", idx, 32'(bub1), 32'(v.bub));
      if (v.dv) begin
        chk("l1_dpc", idx, dpc1, v.dpc);
        chk("l1_mask", idx, 32'(m1), 32'(v.m));
      end
    end
    @(negedge clk);
  endtask

  task automatic chk_reset(input int idx);
    chk("rst_pc1", idx, pc1, 32'h0);
    chk("rst_dv1", idx, 32'(dv1), 32'h0);
    chk("rst_dpc1", idx, dpc1, 32'h0);
    chk("rst_mask1", idx, 32'(m1), 32'h0);
    chk("rst_bub1", idx, 32'(bub1), 32'h0);
    chk("rst_pc3", idx, pc3, 32'h1000);
    chk("rst_dv3", idx, 32'(dv3), 32'h0);
    chk("rst_bub3", idx, 32'(bub3), 32'h0);
  endtask

  initial begin
    //          st il rv rp            | pc            dv dpc           m      bub
    t1.push_back(mk(0,0,0,32'h0,        32'h0,        0, 32'h0,        2'b00, 1));
    t1.push_back(mk(0,0,0,32'h0,        32'h8,        1, 32'h0,        2'b11, 0));
    t1.push_back(mk(0,0,0,32'h0,        32'h10,       1, 32'h8,        2'b11, 0));
    t1.push_back(mk(1,0,0,32'h0,        32'h18,       1, 32'h10,       2'b11, 0));
    t1.push_back(mk(1,0,0,32'h0,        32'h18,       1, 32'h10,       2'b11, 0));
    t1.push_back(mk(1,0,0,32'h0,        32'h18,       1, 32'h10,       2'b11, 0));
    t1.push_back(mk(0,0,0,32'h0,        32'h18,       1, 32'h10,       2'b11, 0));
    t1.push_back(mk(0,0,0,32'h0,        32'h20,       1, 32'h18,       2'b11, 0));
    t1.push_back(mk(0,0,0,32'h0,        32'h28,       1, 32'h20,       2'b11, 0));
    t1.push_back(mk(0,0,0,32'h0,        32'h30,       1, 32'h28,       2'b11, 0));
    t1.push_back(mk(0,0,0,32'h0,        32'h38,       1, 32'h30,       2'b11, 0));
    t1.push_back(mk(0,0,1,32'h104,      32'h40,       1, 32'h38,       2'b11, 0));
    t1.push_back(mk(0,0,0,32'h0,        32'h100,      0, 32'h0,        2'b00, 1));
    t1.push_back(mk(0,0,0,32'h0,        32'h108,      1, 32'h100,      2'b10, 0));
    t1.push_back(mk(0,0,0,32'h0,        32'h110,      1, 32'h108,      2'b11, 0));
    t1.push_back(mk(0,1,1,32'h500,      32'h118,      1, 32'h110,      2'b11, 0));
    t1.push_back(mk(0,1,0,32'h0,        32'h500,      0, 32'h0,        2'b00, 0));
    t1.push_back(mk(0,1,0,32'h0,        32'h500,      0, 32'h0,        2'b00, 0));
    t1.push_back(mk(0,0,0,32'h0,        32'h500,      0, 32'h0,        2'b00, 1));
    t1.push_back(mk(0,0,0,32'h0,        32'h508,      1, 32'h500,      2'b11, 0));
    t1.push_back(mk(0,0,1,32'hFFFFFFF0, 32'h510,      1, 32'h508,      2'b11, 0));
    t1.push_back(mk(0,0,0,32'h0,        32'hFFFFFFF0, 0, 32'h0,        2'b00, 1));
    t1.push_back(mk(0,0,0,32'h0,        32'hFFFFFFF8, 1, 32'hFFFFFFF0, 2'b11, 0));
    t1.push_back(mk(0,0,0,32'h0,        32'h0,        1, 32'hFFFFFFF8, 2'b11, 0));
    t1.push_back(mk(0,0,0,32'h0,        32'h8,        1, 32'h0,        2'b11, 0));

    t3.push_back(mk(0,0,1,32'h200,      32'h1000,     0, 32'h0,        2'b00, 1));
    t3.push_back(mk(0,0,1,32'h300,      32'h200,      0, 32'h0,        2'b00, 1));
    t3.push_back(mk(0,0,0,32'h0,        32'h300,      0, 32'h0,        2'b00, 1));
    t3.push_back(mk(0,0,0,32'h0,        32'h308,      0, 32'h0,        2'b00, 1));
    t3.push_back(mk(0,0,0,32'h0,        32'h310,      0, 32'h0,        2'b00, 1));
    t3.push_back(mk(0,0,0,32'h0,        32'h318,      1, 32'h300,      2'b11, 0));
    t3.push_back(mk(0,0,0,32'h0,        32'h320,      1, 32'h308,      2'b11, 0));
    t3.push_back(mk(0,0,1,32'h404,      32'h328,      1, 32'h310,      2'b11, 0));
    t3.push_back(mk(1,0,0,32'h0,        32'h400,      0, 32'h0,        2'b00, 0));
    t3.push_back(mk(0,0,0,32'h0,        32'h400,      0, 32'h0,        2'b00, 1));
    t3.push_back(mk(0,0,0,32'h0,        32'h408,      0, 32'h0,        2'b00, 1));
    t3.push_back(mk(0,0,0,32'h0,        32'h410,      0, 32'h0,        2'b00, 1));
    t3.push_back(mk(0,0,0,32'h0,        32'h418,      1, 32'h400,      2'b10, 0));
    t3.push_back(mk(0,0,0,32'h0,        32'h420,      1, 32'h408,      2'b11, 0));

    // Power-on reset with inputs idle (advance would be high).
    #12;
    chk_reset(0);
    @(negedge clk);
    rstn = 1'b1;
    foreach (t1[i]) apply(t1[i], 1'b0, i);

    // Asynchronous reset in the middle of a running stream.
    rstn = 1'b0;
    #1;
    chk_reset(1);
    repeat (2) @(negedge clk);
    chk_reset(2);
    rstn = 1'b1;
    foreach (t3[i]) apply(t3[i], 1'b1, i);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL take parameters, one per line: name, default, meaning.
  ROM_LATENCY  1  instruction-ROM read latency in cycles (1..4).
  RESET_PC  32'h0  first fetch address after reset.
  FETCH_BYTES  8  bytes per fetch bundle (two 32-bit slots).
REQ-002 SHALL have ports, one per line: name  direction  width  meaning.
  clk  in  1  single clock, rising edge.
  rstn  in  1  reset, asynchronous, active-low.
  interlock  in  1  downstream hazard hold.
  fetch_stall  in  1  front-end hold.
  redirect_valid  in  1  taken branch/jump resolved this cycle.
  redirect_pc  in  32  branch/jump target (4-byte aligned).
  pc  out  32  ROM address, always 8-byte aligned.
  deliver_valid  out  1  ROM data now on douta belongs to a live bundle.
  deliver_pc  out  32  aligned address of the delivered bundle.
  deliver_mask  out  2  per-slot live bits {slot1, slot0}; dead slots become NOP {3'b111,29'b0} downstream.
  bubble  out  1  deliver_valid low while advancing (perf tap).

Function
REQ-003 SHALL define advance = ~fetch_stall & ~interlock.
REQ-004 SHALL implement states BOOT, RUN, HOLD, FLUSH.
REQ-005 SHALL in BOOT/RUN/FLUSH on advance increment pc by FETCH_BYTES, wrapping modulo 2^32.
REQ-006 SHALL keep pc, in-flight tracker and deliver_* unchanged on ~advance (HOLD); return to the prior state on advance.
REQ-007 SHALL track in-flight bundles in a ROM_LATENCY-deep shift register of {valid, pc, mask}, shifting only on advance; a bundle is pushed with valid=1.
REQ-008 SHALL drive deliver_valid/deliver_pc/deliver_mask from the tracker tail.
REQ-009 SHALL on redirect_valid, regardless of advance, load pc <= {redirect_pc[31:3],3'b0}, clear every tracker valid, enter FLUSH with count ROM_LATENCY.
REQ-010 SHALL push the first bundle after a redirect with mask {1, ~redirect_pc[2]}; all other bundles mask 2'b11.
REQ-011 SHALL decrement the FLUSH count per advance and enter RUN at zero; BOOT behaves identically after reset.
REQ-012 SHALL give redirect priority over stall and interlock in the same cycle; a second redirect during FLUSH restarts FLUSH.
REQ-013 SHALL keep deliver_valid low for exactly ROM_LATENCY advancing cycles after reset or redirect (no-stall case).
REQ-014 SHALL assert bubble = advance & ~deliver_valid.

Reset
REQ-015 SHALL on rstn low asynchronously set pc=RESET_PC, state=BOOT, count=ROM_LATENCY, all tracker valids 0, deliver_valid=0, deliver_pc=0, deliver_mask=2'b00, bubble=0.
REQ-016 SHALL treat reset mid-FLUSH or mid-HOLD identically to power-on reset; release is synchronous to clk via existing reset synchronizer.

Structure
REQ-017 SHALL place state enum, NOP encoding {3'b111,29'b0} and FETCH_BYTES in shared package core_pkg.
REQ-018 SHALL implement the tracker as sub-module fetch_track (parameterised depth shift register with synchronous clear).
REQ-019 SHALL target 150-300 lines RTL, no latches, no combinational path from redirect_valid to deliver_*.

Verification
REQ-020 Reset, no stall, ROM_LATENCY=1 -> pc 0,8,16...; deliver_valid first high cycle 2 with deliver_pc=0, mask 11.
REQ-021 fetch_stall high 3 cycles at pc=24 -> pc stays 24, deliver_pc stays 16, bubble 0; resumes 32 next cycle.
REQ-022 redirect_valid with redirect_pc=0x104 while pc=0x40 -> pc=0x100 next, one bubble, then deliver_pc=0x100 mask 10, then 0x108 mask 11.
REQ-023 redirect_valid with interlock high -> pc still loads target; tracker cleared; deliver_valid 0 until interlock drops and ROM_LATENCY advances elapse.
REQ-024 ROM_LATENCY=3, back-to-back redirects 0x200 then 0x300 -> no bundle from 0x200 delivered; first delivery 0x300 after 3 advances.
REQ-025 pc=0xFFFFFFF8 advance -> pc wraps to 0x0, deliver_pc sequence continues without spurious invalid.
